// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: state encodings, reset PC default, instruction width.
package inst_fetch_pkg;

  localparam int unsigned INST_W       = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  localparam logic [1:0] FS_IDLE  = 2'd0;
  localparam logic [1:0] FS_FETCH = 2'd1;
  localparam logic [1:0] FS_ISSUE = 2'd2;

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// Program counter register: branch load has priority over increment.
module pc_reg #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_pc <= RESET_PC;
    else if (i_load) r_pc <= i_load_addr;
    else if (i_inc)  r_pc <= r_pc + PC_INC;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: memory req/ack on one side, valid/stall to the decoder on the other.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_stall,
  input  logic              i_br_en,
  input  logic [ADDR_W-1:0] i_br_addr,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [INST_W-1:0] i_mem_data,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  output logic              o_valid,
  output logic              o_busy
);

  logic [1:0]        r_state;
  logic              r_kill;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic              w_ack;
  logic              w_deliver;
  logic              w_release;
  logic              w_start;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (i_br_en),
    .i_load_addr (i_br_addr),
    .i_inc       (w_deliver),
    .o_pc        (w_pc)
  );

  assign w_ack     = (r_state == FS_FETCH) && i_mem_ack;
  assign w_deliver = w_ack && !r_kill && !i_br_en;
  assign w_release = (r_state == FS_ISSUE) && (i_br_en || !i_stall);
  // A fetch launched on a branch edge must use the target, not the pc being replaced.
  assign w_fetch_addr = i_br_en ? i_br_addr : w_pc;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      FS_IDLE: begin
        if (i_en && !i_stall) begin
          w_state_nxt = FS_FETCH;
          w_start     = 1'b1;
        end
      end
      FS_FETCH: begin
        if (w_ack) w_state_nxt = w_deliver ? FS_ISSUE : FS_IDLE;
      end
      FS_ISSUE: begin
        if (w_release) begin
          if (i_en) begin
            w_state_nxt = FS_FETCH;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = FS_IDLE;
          end
        end
      end
      default: w_state_nxt = FS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= FS_IDLE;
      r_kill     <= 1'b0;
      o_mem_req  <= 1'b0;
      o_mem_addr <= RESET_PC;
      o_inst     <= '0;
      o_inst_pc  <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      o_busy  <= (w_state_nxt != FS_IDLE);

      if (w_start) begin
        o_mem_req  <= 1'b1;
        o_mem_addr <= w_fetch_addr;
      end else if (w_ack) begin
        o_mem_req  <= 1'b0;
      end

      if (w_ack)                                  r_kill <= 1'b0;
      else if ((r_state == FS_FETCH) && i_br_en)  r_kill <= 1'b1;

      if (w_deliver) begin
        o_inst    <= i_mem_data;
        o_inst_pc <= w_pc;
        o_valid   <= 1'b1;
      end else if (w_release) begin
        o_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with literal checks, then randomized traffic vs a handshake-level model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        stall = 1'b0;
  logic        br_en = 1'b0;
  logic [15:0] br_addr = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        valid;
  logic        busy;

  always #5 clk = ~clk;

  inst_fetch #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000),
    .PC_INC   (16'd1)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_stall    (stall),
    .i_br_en    (br_en),
    .i_br_addr  (br_addr),
    .o_mem_req  (mem_req),
    .o_mem_addr (mem_addr),
    .i_mem_ack  (mem_ack),
    .i_mem_data (mem_data),
    .o_inst     (inst),
    .o_inst_pc  (inst_pc),
    .o_valid    (valid),
    .o_busy     (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model view: an outstanding request, a held instruction, the pc, and a stale-request flag.
  logic        m_req = 1'b0;
  logic        m_kill = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_busy = 1'b0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_inst = '0;
  logic [15:0] m_ipc = '0;
  logic [15:0] m_pc = '0;

  int mem_wait = 0;
  int req_age = 0;
  bit rand_wait = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0077) ? 16'hABCD : 16'h1000 + a;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic        n_req, n_kill, n_valid;
    logic [15:0] n_addr, n_inst, n_ipc, n_pc;
    bit          fetch_go;
    n_req = m_req; n_kill = m_kill; n_valid = m_valid;
    n_addr = m_addr; n_inst = m_inst; n_ipc = m_ipc; n_pc = m_pc;
    fetch_go = 1'b0;
    if (rst) begin
      n_req = 1'b0; n_kill = 1'b0; n_valid = 1'b0;
      n_addr = 16'h0000; n_inst = '0; n_ipc = '0; n_pc = 16'h0000;
    end else begin
      if (m_req) begin
        if (mem_ack) begin
          n_req  = 1'b0;
          n_kill = 1'b0;
          if (!m_kill && !br_en) begin
            n_valid = 1'b1;
            n_inst  = mem_data;
            n_ipc   = m_pc;
            n_pc    = m_pc + 16'd1;
          end
        end else if (br_en) begin
          n_kill = 1'b1;
        end
      end else if (m_valid) begin
        if (br_en || !stall) begin
          n_valid  = 1'b0;
          fetch_go = en;
        end
      end else begin
        fetch_go = en && !stall;
      end
      if (br_en) n_pc = br_addr;
      if (fetch_go) begin
        n_req  = 1'b1;
        n_addr = br_en ? br_addr : m_pc;
      end
    end
    m_req = n_req; m_kill = n_kill; m_valid = n_valid;
    m_addr = n_addr; m_inst = n_inst; m_ipc = n_ipc; m_pc = n_pc;
    m_busy = n_req || n_valid;
  endtask

  task automatic cycle(input bit r, input bit e, input bit s, input bit b,
                       input logic [15:0] ba, input bit spur);
    bit prev_req;
    rst = r; en = e; stall = s; br_en = b; br_addr = ba;
    if (m_req) begin
      mem_ack  = (req_age >= mem_wait);
      mem_data = mem_word(m_addr);
    end else begin
      mem_ack  = spur;
      mem_data = 16'($urandom);
    end
    prev_req = m_req;
    model_step();
    if (m_req && prev_req) req_age++;
    else begin
      req_age = 0;
      if (m_req && rand_wait) mem_wait = $urandom_range(0, 3);
    end
    @(posedge clk);
    #1;
    chk1 ("mem_req",  mem_req,  m_req);
    chk16("mem_addr", mem_addr, m_addr);
    chk1 ("valid",    valid,    m_valid);
    chk16("inst",     inst,     m_inst);
    chk16("inst_pc",  inst_pc,  m_ipc);
    chk1 ("busy",     busy,     m_busy);
  endtask

  task automatic run_to_valid(input bit s);
    for (int unsigned k = 0; k < 20; k++) begin
      cycle(1'b0, 1'b1, s, 1'b0, 16'h0, 1'b0);
      if (m_valid) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_valid: no issue within 20 cycles at %0t", $time);
  endtask

  initial begin
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk1 ("lit_rst_req",   mem_req,  1'b0);
    chk16("lit_rst_addr",  mem_addr, 16'h0000);
    chk1 ("lit_rst_valid", valid,    1'b0);
    chk1 ("lit_rst_busy",  busy,     1'b0);
    chk16("lit_rst_ipc",   inst_pc,  16'h0000);

    // zero-wait streaming: one issue every second cycle
    mem_wait = 0;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk1 ("lit_first_req", mem_req, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      if (i != 0) cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      chk1 ("lit_zw_valid", valid,   1'b1);
      chk16("lit_zw_inst",  inst,    16'h1000 + 16'(i));
      chk16("lit_zw_ipc",   inst_pc, 16'(i));
    end

    // branch out of ISSUE, then hold the issued word under stall
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0077, 1'b0);
    chk1 ("lit_br_flush", valid,    1'b0);
    chk16("lit_br_addr",  mem_addr, 16'h0077);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    for (int unsigned i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      chk16("lit_stall_inst", inst,    16'hABCD);
      chk1 ("lit_stall_req",  mem_req, 1'b0);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk1 ("lit_post_stall_req", mem_req,  1'b1);
    chk16("lit_post_stall_adr", mem_addr, 16'h0078);

    // branch while a 2-wait fetch is pending: the stale word is never issued
    mem_wait = 2;
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b0);
    chk16("lit_kill_hold", mem_addr, 16'h0078);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk1 ("lit_kill_valid", valid,   1'b0);
    chk1 ("lit_kill_req",   mem_req, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk16("lit_refetch", mem_addr, 16'h0040);
    run_to_valid(1'b0);
    chk16("lit_target_ipc", inst_pc, 16'h0040);

    // pc wrap
    mem_wait = 0;
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk16("lit_wrap_ipc0",  inst_pc, 16'hFFFF);
    chk16("lit_wrap_inst0", inst,    16'h0FFF);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk16("lit_wrap_ipc1",  inst_pc, 16'h0000);

    // branch on the same edge as ack
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0020, 1'b0);
    chk1 ("lit_ackbr_valid", valid, 1'b0);
    run_to_valid(1'b0);
    chk16("lit_ackbr_ipc", inst_pc, 16'h0020);

    // reset in the middle of a fetch
    mem_wait = 3;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk1 ("lit_midrst_req",  mem_req,  1'b0);
    chk1 ("lit_midrst_vld",  valid,    1'b0);
    chk16("lit_midrst_addr", mem_addr, 16'h0000);

    rand_wait = 1'b1;
    mem_wait  = 0;
    for (int unsigned i = 0; i < 3000; i++) begin
      logic [15:0] ba;
      ba = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'hFFF0 + 16'($urandom_range(0, 15));
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) < 8,
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 99) < 8,
            ba,
            $urandom_range(0, 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
